// File: rtl/twd_pkg.sv
// Shared types, twiddle constants and the saturation helper for the trivial/W8 twiddle stage.
package twd_pkg;
  typedef enum logic {TWD_M_TRIV = 1'b0, TWD_M_W8 = 1'b1} twd_mode_e;
  typedef enum logic [1:0] {OP_ID, OP_NJ, OP_W8P1, OP_W8P3} twd_op_e;

  localparam int C_W8_Q8   = 181;
  localparam int C_W8_FRAC = 8;

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction
endpackage

// File: rtl/twd_lane_w8.sv
// One complex lane: stage 1 forms products / swap-negate, stage 2 rounds and saturates.
module twd_lane_w8
  import twd_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en1_i,
  input  logic                    en2_i,
  input  twd_op_e                 op_i,
  input  logic signed [WIDTH-1:0] sum_re_i,
  input  logic signed [WIDTH-1:0] sum_im_i,
  input  logic signed [WIDTH-1:0] diff_re_i,
  input  logic signed [WIDTH-1:0] diff_im_i,
  output logic signed [WIDTH-1:0] sum_re_o,
  output logic signed [WIDTH-1:0] sum_im_o,
  output logic signed [WIDTH-1:0] diff_re_o,
  output logic signed [WIDTH-1:0] diff_im_o,
  output logic                    sat_o
);
  localparam int SW = WIDTH + 1;
  localparam int PW = WIDTH + 10;
  localparam logic signed [PW-1:0] C_X = PW'(C_W8_Q8);
  localparam logic signed [PW-1:0] RND = PW'(1 << (C_W8_FRAC - 1));

  logic signed [SW-1:0]    s, d;
  logic signed [PW-1:0]    ps, pd;
  logic signed [PW-1:0]    p_re_d, p_im_d, p_re_q, p_im_q;
  logic                    scl_d, scl_q;
  logic signed [WIDTH-1:0] sum_re1_q, sum_im1_q, sum_re2_q, sum_im2_q;
  logic signed [WIDTH-1:0] diff_re2_q, diff_im2_q;
  logic signed [PW-1:0]    r_re, r_im;
  logic signed [63:0]      c_re, c_im;

  assign s  = SW'(diff_re_i) + SW'(diff_im_i);
  assign d  = SW'(diff_im_i) - SW'(diff_re_i);
  assign ps = PW'(s) * C_X;
  assign pd = PW'(d) * C_X;

  // Trivial ops are carried at product width unscaled so stage 2 shares one clamp path.
  always_comb begin
    p_re_d = PW'(diff_re_i);
    p_im_d = PW'(diff_im_i);
    scl_d  = 1'b0;
    case (op_i)
      OP_NJ:   begin p_re_d = PW'(diff_im_i); p_im_d = -PW'(diff_re_i); end
      OP_W8P1: begin p_re_d = ps; p_im_d = pd;  scl_d = 1'b1; end
      OP_W8P3: begin p_re_d = pd; p_im_d = -ps; scl_d = 1'b1; end
      default: ;
    endcase
  end

  assign r_re  = scl_q ? (p_re_q + RND) >>> C_W8_FRAC : p_re_q;
  assign r_im  = scl_q ? (p_im_q + RND) >>> C_W8_FRAC : p_im_q;
  assign c_re  = sat_w(64'(r_re), WIDTH);
  assign c_im  = sat_w(64'(r_im), WIDTH);
  assign sat_o = (c_re != 64'(r_re)) | (c_im != 64'(r_im));

  always_ff @(posedge clk) begin
    if (rst) begin
      p_re_q     <= '0;
      p_im_q     <= '0;
      scl_q      <= 1'b0;
      sum_re1_q  <= '0;
      sum_im1_q  <= '0;
      sum_re2_q  <= '0;
      sum_im2_q  <= '0;
      diff_re2_q <= '0;
      diff_im2_q <= '0;
    end else begin
      if (en1_i) begin
        p_re_q    <= p_re_d;
        p_im_q    <= p_im_d;
        scl_q     <= scl_d;
        sum_re1_q <= sum_re_i;
        sum_im1_q <= sum_im_i;
      end
      if (en2_i) begin
        sum_re2_q  <= sum_re1_q;
        sum_im2_q  <= sum_im1_q;
        diff_re2_q <= WIDTH'(c_re);
        diff_im2_q <= WIDTH'(c_im);
      end
    end
  end

  assign sum_re_o  = sum_re2_q;
  assign sum_im_o  = sum_im2_q;
  assign diff_re_o = diff_re2_q;
  assign diff_im_o = diff_im2_q;
endmodule

// File: rtl/twd_mul_trivial_pipe.sv
// Per-group trivial / W8 twiddle on the butterfly difference path, sum path passed aligned.
module twd_mul_trivial_pipe
  import twd_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int LANES      = 16,
  parameter int BLK_CLKS   = 4,
  parameter int NUM_GROUPS = 4,
  parameter int MODE       = 0,
  localparam int GW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_sof,
  input  logic signed [WIDTH-1:0] i_sum_re  [LANES],
  input  logic signed [WIDTH-1:0] i_sum_im  [LANES],
  input  logic signed [WIDTH-1:0] i_diff_re [LANES],
  input  logic signed [WIDTH-1:0] i_diff_im [LANES],
  input  logic                    i_sat_clr,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic [GW-1:0]           o_grp,
  output logic signed [WIDTH-1:0] o_sum_re  [LANES],
  output logic signed [WIDTH-1:0] o_sum_im  [LANES],
  output logic signed [WIDTH-1:0] o_diff_re [LANES],
  output logic signed [WIDTH-1:0] o_diff_im [LANES],
  output logic                    o_sat_sticky
);
  localparam int STAGES = 2;
  localparam int FRAME  = BLK_CLKS * NUM_GROUPS;
  localparam int CW     = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  if (MODE == int'(TWD_M_W8) && NUM_GROUPS != 4) begin : g_mode_chk
    $error("twd_mul_trivial_pipe: MODE=1 requires NUM_GROUPS=4");
  end
  if (MODE != int'(TWD_M_TRIV) && MODE != int'(TWD_M_W8)) begin : g_mode_rng
    $error("twd_mul_trivial_pipe: MODE must be 0 or 1");
  end

  logic [CW-1:0]     cnt_q, cnt_d, cur_cnt;
  logic [GW-1:0]     grp, grp1_q, grp2_q;
  twd_op_e           op;
  logic [STAGES:1]   vld_pipe, sof_pipe;
  logic [LANES-1:0]  lane_sat;
  logic              sticky_q, sticky_d;

  assign cur_cnt = (i_valid & i_sof) ? '0 : cnt_q;
  assign grp     = GW'(cur_cnt / CW'(BLK_CLKS));

  always_comb begin
    cnt_d = cnt_q;
    if (i_valid) cnt_d = (cur_cnt == LAST) ? '0 : cur_cnt + 1'b1;
  end

  always_comb begin
    op = OP_ID;
    if (MODE == int'(TWD_M_W8)) begin
      case (int'(grp))
        1:       op = OP_W8P1;
        2:       op = OP_NJ;
        3:       op = OP_W8P3;
        default: op = OP_ID;
      endcase
    end else if (int'(grp) == NUM_GROUPS - 1) begin
      op = OP_NJ;
    end
  end

  // Set wins over clear: a saturating beat landing with a clear still reports.
  always_comb begin
    sticky_d = i_sat_clr ? 1'b0 : sticky_q;
    if (vld_pipe[1] && (|lane_sat)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      vld_pipe <= '0;
      sof_pipe <= '0;
      grp1_q   <= '0;
      grp2_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
      sof_pipe <= {sof_pipe[STAGES-1:1], i_valid & i_sof};
      if (i_valid)     grp1_q <= grp;
      if (vld_pipe[1]) grp2_q <= grp1_q;
      sticky_q <= sticky_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    twd_lane_w8 #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en1_i     (i_valid),
      .en2_i     (vld_pipe[1]),
      .op_i      (op),
      .sum_re_i  (i_sum_re[l]),
      .sum_im_i  (i_sum_im[l]),
      .diff_re_i (i_diff_re[l]),
      .diff_im_i (i_diff_im[l]),
      .sum_re_o  (o_sum_re[l]),
      .sum_im_o  (o_sum_im[l]),
      .diff_re_o (o_diff_re[l]),
      .diff_im_o (o_diff_im[l]),
      .sat_o     (lane_sat[l])
    );
  end

  assign o_valid      = vld_pipe[STAGES];
  assign o_sof        = sof_pipe[STAGES];
  assign o_grp        = grp2_q;
  assign o_sat_sticky = sticky_q;
endmodule

// File: tb/tb_twd_mul_trivial_pipe.sv
// Scoreboard bench driving a MODE0 and a MODE1 instance with identical stimulus.
module tb_twd_mul_trivial_pipe;
  localparam int W = 12, L = 16, NG = 4, BC = 4;

  logic clk = 1'b0;
  logic rst, i_valid, i_sof, i_sat_clr;
  logic signed [W-1:0] i_sum_re [L], i_sum_im [L], i_diff_re [L], i_diff_im [L];
  logic v0, v1, s0, s1, st0, st1;
  logic [1:0] g0, g1;
  logic signed [W-1:0] sr0 [L], si0 [L], dr0 [L], di0 [L];
  logic signed [W-1:0] sr1 [L], si1 [L], dr1 [L], di1 [L];

  always #5 clk = ~clk;

  twd_mul_trivial_pipe #(.WIDTH(W), .LANES(L), .BLK_CLKS(BC), .NUM_GROUPS(NG), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof),
    .i_sum_re(i_sum_re), .i_sum_im(i_sum_im), .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
    .i_sat_clr(i_sat_clr), .o_valid(v0), .o_sof(s0), .o_grp(g0),
    .o_sum_re(sr0), .o_sum_im(si0), .o_diff_re(dr0), .o_diff_im(di0), .o_sat_sticky(st0));

  twd_mul_trivial_pipe #(.WIDTH(W), .LANES(L), .BLK_CLKS(BC), .NUM_GROUPS(NG), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof),
    .i_sum_re(i_sum_re), .i_sum_im(i_sum_im), .i_diff_re(i_diff_re), .i_diff_im(i_diff_im),
    .i_sat_clr(i_sat_clr), .o_valid(v1), .o_sof(s1), .o_grp(g1),
    .o_sum_re(sr1), .o_sum_im(si1), .o_diff_re(dr1), .o_diff_im(di1), .o_sat_sticky(st1));

  typedef struct {int grp; bit sof; int a; int b; int sr; int si; int cyc;} item_t;
  item_t q[$];
  item_t e;
  bit got;
  int cyc = 0, cnt_m = 0, asserts = 0, fails = 0;

  function automatic int clamp(input int x, output bit s);
    s = 1'b0;
    if (x > 2047)  begin s = 1'b1; return 2047;  end
    if (x < -2048) begin s = 1'b1; return -2048; end
    return x;
  endfunction

  function automatic void model(input int mode, input int grp, input int a, input int b,
                                output int re, output int im, output bit sat);
    int op, r0, i0;
    bit sr, si;
    if (mode == 0) op = (grp == NG - 1) ? 1 : 0;
    else op = (grp == 0) ? 0 : (grp == 1) ? 2 : (grp == 2) ? 1 : 3;
    case (op)
      0:       begin r0 = a; i0 = b; end
      1:       begin r0 = b; i0 = -a; end
      2:       begin r0 = ((a + b) * 181 + 128) >>> 8; i0 = ((b - a) * 181 + 128) >>> 8; end
      default: begin r0 = ((b - a) * 181 + 128) >>> 8; i0 = (-((a + b) * 181) + 128) >>> 8; end
    endcase
    re  = clamp(r0, sr);
    im  = clamp(i0, si);
    sat = sr | si;
  endfunction

  task automatic drive(input bit sof, input int a, input int b, input int sr, input int si);
    int cur;
    item_t it;
    cur   = sof ? 0 : cnt_m;
    cnt_m = (cur == NG * BC - 1) ? 0 : cur + 1;
    i_valid = 1'b1;
    i_sof   = sof;
    for (int l = 0; l < L; l++) begin
      i_diff_re[l] = W'(a);
      i_diff_im[l] = W'(b + l);
      i_sum_re[l]  = W'(sr + l);
      i_sum_im[l]  = W'(si - l);
    end
    it = '{cur / BC, sof, a, b, sr, si, cyc};
    q.push_back(it);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    got = 1'b0;
    if (v0) begin
      if (q.size() == 0) begin
        asserts++; fails++;
        $display("FAIL sb_empty: o_valid=1 at cycle %0d with no beat expected", cyc);
      end else begin
        e = q.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    bit nz;
    rst = 1'b1; i_sat_clr = 1'b0;
    i_valid = 1'b1; i_sof = 1'b1;
    for (int l = 0; l < L; l++) begin
      i_diff_re[l] = 12'sd321; i_diff_im[l] = -12'sd45;
      i_sum_re[l] = 12'sd9;    i_sum_im[l] = 12'sd11;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      nz = 1'b0;
      for (int l = 0; l < L; l++)
        nz |= (sr0[l] != 0) | (si0[l] != 0) | (dr0[l] != 0) | (di0[l] != 0) |
              (dr1[l] != 0) | (di1[l] != 0);
      asserts++;
      if ({v0, s0, g0, st0, v1, s1, g1, st1, nz} !== 11'b0) begin
        fails++;
        $display("FAIL reset_state c%0d: v=%b sof=%b grp=%0d sticky=%b v1=%b nz=%b, want all 0",
                 c, v0, s0, g0, st0, v1, nz);
      end
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_mode0_b2b();
    int er, ei;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(k == 0, 100, -50, 7, 8); else idle();
      tick();
      if (got) begin
        asserts++;
        if (g0 !== 2'(e.grp) || cyc - e.cyc != 2) begin
          fails++;
          $display("FAIL b2b_grp_lat: grp=%0d lat=%0d, want grp=%0d lat=2", g0, cyc - e.cyc, e.grp);
        end
        for (int l = 0; l < L; l++) begin
          er = (e.grp == 3) ? -50 + l : 100;
          ei = (e.grp == 3) ? -100 : -50 + l;
          asserts++;
          if (dr0[l] !== W'(er) || di0[l] !== W'(ei) || sr0[l] !== W'(7 + l) || si0[l] !== W'(8 - l)) begin
            fails++;
            $display("FAIL b2b_data lane%0d grp%0d: diff=(%0d,%0d) sum=(%0d,%0d), want (%0d,%0d) (%0d,%0d)",
                     l, e.grp, dr0[l], di0[l], sr0[l], si0[l], er, ei, 7 + l, 8 - l);
          end
        end
      end
    end
  endtask

  task automatic test_sat();
    bit pre;
    i_sat_clr = 1'b1; tick(); i_sat_clr = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k < 12) drive(k == 0, 100, -50, 0, 0);
      else if (k == 12) drive(1'b0, -2048, 5, 0, 0);
      else idle();
      pre = st0;
      tick();
      if (got && e.a == -2048) begin
        asserts++;
        if (st0 !== 1'b1 || pre !== 1'b0) begin
          fails++;
          $display("FAIL sat_set: sticky before=%b at=%b, want 0 then 1", pre, st0);
        end
        for (int l = 0; l < L; l++) begin
          asserts++;
          if (dr0[l] !== W'(5 + l) || di0[l] !== 12'sd2047) begin
            fails++;
            $display("FAIL sat_data lane%0d: (%0d,%0d), want (%0d,2047)", l, dr0[l], di0[l], 5 + l);
          end
        end
      end else if (got) begin
        asserts++;
        if (st0 !== 1'b0) begin
          fails++;
          $display("FAIL sat_early: sticky=%b before saturating beat, want 0", st0);
        end
      end
    end
    i_sat_clr = 1'b1; tick(); i_sat_clr = 1'b0;
    asserts++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL sat_clr: sticky=%b, want 0", st0); end
    drive(1'b0, -2048, 5, 0, 0);
    tick();
    idle();
    i_sat_clr = 1'b1;
    tick();
    i_sat_clr = 1'b0;
    asserts++;
    if (!got || st0 !== 1'b1 || di0[0] !== 12'sd2047) begin
      fails++;
      $display("FAIL sat_set_wins: got=%b sticky=%b im=%0d, want 1 1 2047", got, st0, di0[0]);
    end
    i_sat_clr = 1'b1; tick(); i_sat_clr = 1'b0;
    asserts++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL sat_clr2: sticky=%b, want 0", st0); end
  endtask

  task automatic test_mode1();
    int tre[4] = '{1000, 707, 0, -707};
    int tim[4] = '{0, -707, -1000, -707};
    int mr, mi;
    bit ms;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(k == 0, 1000, 0, 1, 2); else idle();
      tick();
      if (got) begin
        asserts++;
        if (g1 !== 2'(e.grp) || dr1[0] !== W'(tre[e.grp]) || di1[0] !== W'(tim[e.grp])) begin
          fails++;
          $display("FAIL w8_lane0 grp%0d: grp=%0d (%0d,%0d), want (%0d,%0d)",
                   e.grp, g1, dr1[0], di1[0], tre[e.grp], tim[e.grp]);
        end
        for (int l = 1; l < L; l++) begin
          model(1, e.grp, 1000, l, mr, mi, ms);
          asserts++;
          if (dr1[l] !== W'(mr) || di1[l] !== W'(mi)) begin
            fails++;
            $display("FAIL w8_lane%0d grp%0d: (%0d,%0d), want (%0d,%0d)", l, e.grp, dr1[l], di1[l], mr, mi);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    int mr0, mi0, mr1, mi1, gap;
    bit ms, have = 1'b0;
    logic signed [W-1:0] lr = '0, li = '0;
    logic [1:0] lg = '0;
    for (int k = 0; k < 16; k++) begin
      gap = $urandom_range(1, 5);
      for (int c = 0; c <= gap; c++) begin
        if (c == 0) drive(k == 0 || k == 6, 10 * k + 3, -7 * k, k, -k); else idle();
        tick();
        if (got) begin
          for (int l = 0; l < L; l++) begin
            model(0, e.grp, e.a, e.b + l, mr0, mi0, ms);
            model(1, e.grp, e.a, e.b + l, mr1, mi1, ms);
            asserts++;
            if (g0 !== 2'(e.grp) || s0 !== e.sof || dr0[l] !== W'(mr0) || di0[l] !== W'(mi0) ||
                dr1[l] !== W'(mr1) || di1[l] !== W'(mi1) || sr0[l] !== W'(e.sr + l)) begin
              fails++;
              $display("FAIL gap_beat a=%0d lane%0d: grp=%0d sof=%b m0=(%0d,%0d) m1=(%0d,%0d) want grp=%0d sof=%b m0=(%0d,%0d) m1=(%0d,%0d)",
                       e.a, l, g0, s0, dr0[l], di0[l], dr1[l], di1[l], e.grp, e.sof, mr0, mi0, mr1, mi1);
            end
          end
          if (e.a == 63) begin
            asserts++;
            if (g0 !== 2'd0 || s0 !== 1'b1) begin
              fails++;
              $display("FAIL resync_beat6: grp=%0d sof=%b, want 0 1", g0, s0);
            end
          end
          lr = dr0[0]; li = di0[0]; lg = g0; have = 1'b1;
        end else if (have) begin
          asserts++;
          if (v0 !== 1'b0 || dr0[0] !== lr || di0[0] !== li || g0 !== lg) begin
            fails++;
            $display("FAIL gap_hold: v=%b (%0d,%0d) grp=%0d, want 0 (%0d,%0d) grp=%0d",
                     v0, dr0[0], di0[0], g0, lr, li, lg);
          end
        end
      end
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    int pops = 0;
    for (int k = 0; k < 9; k++) begin
      drive(k == 0, 50 + k, 1, 0, 0);
      tick();
    end
    rst = 1'b1; i_valid = 1'b1; i_sof = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    q.delete();
    cnt_m = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      asserts++;
      if (v0 !== 1'b0) begin fails++; $display("FAIL rst_flush c%0d: o_valid=%b, want 0", c, v0); end
    end
    drive(1'b0, 300, 4, 0, 0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      if (got) begin
        pops++;
        asserts++;
        if (g0 !== 2'd0 || dr0[0] !== 12'sd300 || di0[0] !== 12'sd4) begin
          fails++;
          $display("FAIL rst_first_beat: grp=%0d (%0d,%0d), want 0 (300,4)", g0, dr0[0], di0[0]);
        end
      end
    end
    asserts++;
    if (pops != 1) begin fails++; $display("FAIL rst_beat_count: %0d beats out, want 1", pops); end
  endtask

  initial begin
    test_reset();
    test_mode0_b2b();
    test_sat();
    test_mode1();
    test_gaps();
    test_reset_midframe();
    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d beats never came out, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/twd_mul_trivial_pipe.md
Name: twd_mul_trivial_pipe

Overview:
Parametrised successor to the fixed 16-lane "-j on last group" twiddle stage. It sits between the radix-2 butterfly stage and the next FFT stage. The block applies a per-group trivial or W8 twiddle to the butterfly difference path and passes the sum path through aligned. The output is registered with a valid/start-of-frame pipeline, saturation handling and a sticky overflow flag.

Parameters:
WIDTH, 12, signed sample width for re/im, Q<6.6>.
LANES, 16, parallel complex lanes per beat.
BLK_CLKS, 4, valid beats per twiddle group.
NUM_GROUPS, 4, groups per frame. Frame length = BLK_CLKS*NUM_GROUPS valid beats.
MODE, 0, twiddle set selection:
- 0 = identity for groups 0..NUM_GROUPS-2, -j for the last group.
- 1 = W8^g for group g; requires NUM_GROUPS=4, elaboration error otherwise.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  input beat valid
i_sof  in  1  start of frame; meaningful only with i_valid
i_sum_re/i_sum_im  in  signed [WIDTH-1:0] x [0:LANES-1]  butterfly sum path
i_diff_re/i_diff_im  in  signed [WIDTH-1:0] x [0:LANES-1]  butterfly difference path
i_sat_clr  in  1  clears o_sat_sticky
o_valid  out  1  output beat valid
o_sof  out  1  aligned start of frame
o_grp  out  $clog2(NUM_GROUPS)  group index of the output beat
o_sum_re/o_sum_im/o_diff_re/o_diff_im  out  signed [WIDTH-1:0] x [0:LANES-1]  twiddled outputs
o_sat_sticky  out  1  set when any lane saturated since the last clear

Behaviour:
- Reset (rst=1 at posedge): counter=0, all pipeline registers=0, o_valid=0, o_sof=0, o_grp=0, all data outputs=0, o_sat_sticky=0. Reset mid-frame discards in-flight beats; the next accepted beat is group 0.
- Beat counter (range 0..BLK_CLKS*NUM_GROUPS-1):
  - Advances only on i_valid and wraps to 0 after the last beat.
  - i_valid & i_sof forces the current beat to count 0 and the counter to 1 next.
  - grp = cnt / BLK_CLKS, computed for the current beat before increment.
- Pipeline: fixed latency of 2 cycles.
  - Stage 1 registers the products / swap-negate results.
  - Stage 2 rounds, saturates and registers the outputs.
  - Each stage's data/grp/sof registers load only when that stage's valid is 1, so outputs hold their last value during gaps.
  - o_valid and o_sof are the 2-cycle-delayed i_valid and (i_valid & i_sof).
- Sum path is delayed 2 cycles, unmodified.
- Diff path, with x = a + jb:
  - Identity: (a, b).
  - -j: (b, -a).
  - W8^1: ((a+b)C, (b-a)C).
  - W8^3: ((b-a)C, -(a+b)C).
  - W8^0 is identity; W8^2 is -j.
- Arithmetic rules:
  - C = 181, Q0.8 (0.70703).
  - a±b is computed at WIDTH+1 bits; products are WIDTH+10 bits.
  - Rounding: add 128, arithmetic shift right 8.
- Saturation: every diff result (including -a with a = -2^(WIDTH-1)) clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- o_sat_sticky:
  - Sets in the cycle the saturating beat appears on the outputs.
  - i_sat_clr clears it; if a set and a clear occur in the same cycle, set wins.
- Simultaneous i_sof with a counter wrap: i_sof wins, so the result is the same.

Decomposition:
- twd_pkg holds:
  - twd_mode_e {TWD_M_TRIV, TWD_M_W8}.
  - C_W8_Q8 = 181.
  - C_W8_FRAC = 8.
  - A sat_w function (saturate to width w).
- Sub-module twd_lane_w8: one complex lane with the 2-stage arithmetic and a sat flag. The top generates LANES instances and owns the counter and the valid/sof/grp pipeline.

Test Plan:
1. Reset: rst=1 for 3 cycles with i_valid=1 and nonzero data -> all outputs 0, o_valid=0, o_sat_sticky=0 throughout.
2. MODE0, 16 back-to-back beats, all lanes diff=(100,-50), sum=(7,8):
   - Beats 0-11 -> diff out (100,-50).
   - Beats 12-15 -> (-50,-100).
   - Sum out is always (7,8).
   - o_valid is high 2 cycles after each input; o_grp is 0,0,0,0,1,…,3.
3. MODE0 saturation: last-group beat with diff_re=-2048, diff_im=5 -> out (5,2047), o_sat_sticky=1 on the same output cycle. Pulsing i_sat_clr clears it; a set coinciding with the clear leaves it at 1.
4. MODE1, diff=(1000,0):
   - Group 1 -> (707,-707).
   - Group 2 -> (0,-1000).
   - Group 3 -> (-707,-707).
   - Group 0 -> (1000,0).
5. Gaps/resync: i_valid low for 1-5 random cycles between beats -> group sequence unchanged and outputs held during gaps. i_sof on beat 6 -> that beat reports o_grp=0 and o_sof=1.
6. Reset mid-frame: assert rst during beat 9 -> next valid beat after release reports o_grp=0, and no pre-reset beat appears on the outputs.
